// File: rtl/s32_stream_sched.sv
// s32_stream_sched: two-requester round-robin scheduler feeding the 32->16 stream adapter
module s32_stream_sched #(
  parameter int GAP = 2,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] s32,
  output logic        n32rdy,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] word_cnt
);
  localparam int G = GAP < 2 ? 2 : GAP;
  localparam logic [15:0] GAP_LD = 16'(G - 1);
  localparam logic [15:0] BL = 16'(BURST_LEN);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [15:0] gap_cnt, gap_d, burst_cnt, burst_d, word_d;
  logic [31:0] s32_d;
  logic [1:0]  grant_d;
  logic        last_owner, last_d, n32rdy_d;
  logic        slot_open, owner, keep, any, sel, fire;
  assign slot_open  = (gap_cnt == 16'd0) & ~rst;
  assign req0_ready = fire & ~sel;
  assign req1_ready = fire & sel;
  assign busy       = (state != IDLE) | (gap_cnt != 16'd0);
  // arbitration and next-state: owner keeps the slot until its burst limit, otherwise alternate
  always_comb begin
    owner    = grant[1];
    any      = req0_valid | req1_valid;
    keep     = (state == GRANT) & (owner ? req1_valid : req0_valid) & (burst_cnt < BL);
    sel      = keep ? owner : (req0_valid & req1_valid) ? ~last_owner : req1_valid;
    fire     = slot_open & any;
    state_d  = fire ? GRANT : slot_open ? IDLE : state;
    grant_d  = fire ? (sel ? 2'b10 : 2'b01) : slot_open ? 2'b00 : grant;
    burst_d  = fire ? (keep ? burst_cnt + 16'd1 : 16'd1) : slot_open ? 16'd0 : burst_cnt;
    gap_d    = fire ? GAP_LD : (gap_cnt != 16'd0) ? gap_cnt - 16'd1 : gap_cnt;
    last_d   = fire ? sel : last_owner;
    s32_d    = fire ? (sel ? req1_data : req0_data) : s32;
    word_d   = word_cnt + {15'd0, fire};
    n32rdy_d = fire;
  end
  // state register; last_owner resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= 16'd0;
      burst_cnt  <= 16'd0;
      last_owner <= 1'b1;
      s32        <= 32'd0;
      n32rdy     <= 1'b0;
      grant      <= 2'b00;
      word_cnt   <= 16'd0;
    end else begin
      state      <= state_d;
      gap_cnt    <= gap_d;
      burst_cnt  <= burst_d;
      last_owner <= last_d;
      s32        <= s32_d;
      n32rdy     <= n32rdy_d;
      grant      <= grant_d;
      word_cnt   <= word_d;
    end
  end
endmodule
